// File: rtl/cfi_campaign_ctrl_pkg.sv
// Shared types and constants for the CFI fault-injection campaign controller.
package cfi_camp_pkg;

    typedef enum logic [2:0] {IDLE, G, F, N, DONE} state_t;

    localparam logic [1:0] FT_NONE = 2'd0;
    localparam logic [1:0] FT_SA0  = 2'd1;
    localparam logic [1:0] FT_SA1  = 2'd2;
    localparam logic [1:0] FT_INV  = 2'd3;

    localparam int unsigned NUM_LOC    = 8;
    localparam int unsigned NUM_FAULTS = 24;

    localparam int unsigned LFSR_W      = 20;
    localparam int unsigned LFSR_TAP_HI = 19;
    localparam int unsigned LFSR_TAP_LO = 16;

    // Fibonacci step for x^20 + x^17 + 1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/cfi_campaign_ctrl_lfsr20.sv
// 20-bit operand LFSR with synchronous seed load; load has priority over advance.
module lfsr20
    import cfi_camp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= seed;
        else if (en)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/cfi_campaign_ctrl.sv
// Exhaustive 24-fault campaign sequencer for the CFI datapath.
// Optional CFI_CAMP_MAP_EN adds a per-fault detection bitmap output det_map.
module cfi_campaign_ctrl
    import cfi_camp_pkg::*;
#(
    parameter int unsigned       NUM_PAT   = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 20'h00001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  cfi_a,
    output logic [3:0]  cfi_b,
    output logic [7:0]  cfi_c,
    output logic [2:0]  cfi_loc,
    output logic [1:0]  cfi_type,
    input  logic [7:0]  cfi_y,
    output logic [4:0]  det_cnt
`ifdef CFI_CAMP_MAP_EN
   ,output logic [NUM_FAULTS-1:0] det_map
`endif
);

    localparam logic [7:0] LAST_PAT = 8'(NUM_PAT - 1);
    localparam logic [2:0] LAST_LOC = 3'(NUM_LOC - 1);

    state_t            state;
    logic [2:0]        loc;
    logic [1:0]        ftype;
    logic [7:0]        pat_idx;
    logic [7:0]        golden;
    logic              hit;
    logic              lfsr_load;
    logic              lfsr_en;
    logic [LFSR_W-1:0] lfsr_q;

    always_comb begin
        lfsr_load = ((state == IDLE || state == DONE) && start) || (state == N);
        lfsr_en   = (state == F);
    end

    lfsr20 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Operands come straight off the LFSR flops: they hold across G and F of a pattern.
    assign cfi_a   = lfsr_q[19:12];
    assign cfi_b   = lfsr_q[11:8];
    assign cfi_c   = lfsr_q[7:0];
    assign cfi_loc = loc;

`ifdef CFI_CAMP_MAP_EN
    logic [4:0] map_idx;
    always_comb map_idx = {2'b00, loc} * 5'd3 + {3'b000, ftype} - 5'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            det_cnt  <= '0;
            cfi_type <= FT_NONE;
            loc      <= '0;
            ftype    <= FT_NONE;
            pat_idx  <= '0;
            golden   <= '0;
            hit      <= 1'b0;
`ifdef CFI_CAMP_MAP_EN
            det_map  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= G;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        det_cnt <= '0;
                        loc     <= '0;
                        ftype   <= FT_SA0;
                        pat_idx <= '0;
                        hit     <= 1'b0;
`ifdef CFI_CAMP_MAP_EN
                        det_map <= '0;
`endif
                    end
                end
                G: begin
                    golden   <= cfi_y;
                    cfi_type <= ftype;
                    state    <= F;
                end
                F: begin
                    if (cfi_y != golden)
                        hit <= 1'b1;
                    cfi_type <= FT_NONE;
                    if (pat_idx == LAST_PAT) begin
                        pat_idx <= '0;
                        state   <= N;
                    end else begin
                        pat_idx <= pat_idx + 8'd1;
                        state   <= G;
                    end
                end
                N: begin
                    det_cnt <= det_cnt + {4'd0, hit};
`ifdef CFI_CAMP_MAP_EN
                    if (hit)
                        det_map[map_idx] <= 1'b1;
`endif
                    hit <= 1'b0;
                    if (ftype != FT_INV) begin
                        ftype <= ftype + 2'd1;
                    end else begin
                        ftype <= FT_SA0;
                        loc   <= loc + 3'd1;
                    end
                    if (loc == LAST_LOC && ftype == FT_INV) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= G;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfi_campaign_ctrl.sv
// Directed bench: two controller instances (NUM_PAT=16 and NUM_PAT=1) driving behavioural CFI models.
module tb_cfi_campaign_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset  = 1'b1;
    logic start16 = 1'b0;
    logic start1  = 1'b0;
    bit   bf16    = 1'b0;

    logic       busy16, done16, busy1, done1;
    logic [7:0] a16, c16, y16, a1, c1, y1;
    logic [3:0] b16, b1;
    logic [2:0] loc16, loc1;
    logic [1:0] type16, type1;
    logic [4:0] cnt16, cnt1;
`ifdef CFI_CAMP_MAP_EN
    logic [23:0] map16, map1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Y = A ^ C; in bit-fault mode f_type forces/inverts Y[f_loc]
    function automatic logic [7:0] cfi_eval(input logic [7:0] a, input logic [7:0] c,
                                            input logic [2:0] loc, input logic [1:0] t,
                                            input bit bf);
        logic [7:0] y;
        y = a ^ c;
        if (bf) begin
            case (t)
                2'd1: y[loc] = 1'b0;
                2'd2: y[loc] = 1'b1;
                2'd3: y[loc] = ~y[loc];
                default: ;
            endcase
        end
        return y;
    endfunction

    always_comb y16 = cfi_eval(a16, c16, loc16, type16, bf16);
    always_comb y1  = cfi_eval(a1, c1, loc1, type1, 1'b1);

    cfi_campaign_ctrl #(.NUM_PAT(16), .LFSR_SEED(20'h00001)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .busy(busy16), .done(done16),
        .cfi_a(a16), .cfi_b(b16), .cfi_c(c16), .cfi_loc(loc16), .cfi_type(type16),
        .cfi_y(y16), .det_cnt(cnt16)
`ifdef CFI_CAMP_MAP_EN
       ,.det_map(map16)
`endif
    );

    cfi_campaign_ctrl #(.NUM_PAT(1), .LFSR_SEED(20'h00001)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .cfi_a(a1), .cfi_b(b1), .cfi_c(c1), .cfi_loc(loc1), .cfi_type(type1),
        .cfi_y(y1), .det_cnt(cnt1)
`ifdef CFI_CAMP_MAP_EN
       ,.det_map(map1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle16(input string tag);
        check({tag, "_busy"}, busy16, 0);
        check({tag, "_done"}, done16, 0);
        check({tag, "_cnt"}, cnt16, 0);
        check({tag, "_ops"}, {a16, b16, c16}, 0);
        check({tag, "_loc"}, loc16, 0);
        check({tag, "_type"}, type16, 0);
    endtask

    // Starts dut16 and follows it cycle by cycle; optionally resets at abort_at.
    task automatic run16(input string tag, input int abort_at, input bit pulse_mid,
                         input logic [4:0] exp_cnt, input logic [23:0] exp_map);
        int k_done = 0;
        int busy_cycles = 0;
        int bad_type = 0;
        int bad_ops = 0;
        int f, p;
        logic [1:0]  et;
        logic [19:0] lf = 20'h00001;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check({tag, "_start_clr_done"}, done16, 0);
        check({tag, "_start_clr_cnt"}, cnt16, 0);
        for (int k = 1; k <= 900; k++) begin
            f  = (k - 1) / 33;
            p  = (k - 1) % 33;
            et = 2'd0;
            if (k <= 792 && (p % 2) == 1)
                et = 2'((f % 3) + 1);
            if (type16 !== et) bad_type++;
            if (et != 2'd0 && loc16 !== 3'(f / 3)) bad_type++;
            if (f == 0 && (p % 2) == 0 && p < 20) begin
                if ({a16, b16, c16} !== lf) bad_ops++;
                lf = {lf[18:0], lf[19] ^ lf[16]};
            end
            if (busy16) busy_cycles++;
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_idle16({tag, "_abort"});
                check({tag, "_abort_type"}, bad_type, 0);
                check({tag, "_abort_ops"}, bad_ops, 0);
                return;
            end
            if (done16) begin
                k_done = k;
                break;
            end
            start16 = pulse_mid && (k == 5 || k == 300 || k == 700);
            @(negedge clk);
        end
        start16 = 1'b0;
        check({tag, "_busy_cycles"}, busy_cycles, 792);
        check({tag, "_done_cycle"}, k_done, 793);
        check({tag, "_type_only_in_F"}, bad_type, 0);
        check({tag, "_first_ops"}, bad_ops, 0);
        check({tag, "_det_cnt"}, cnt16, exp_cnt);
`ifdef CFI_CAMP_MAP_EN
        check({tag, "_det_map"}, map16, exp_map);
`else
        if (exp_map == 24'hx) $display("unreachable");
`endif
    endtask

    initial begin
        int k_done;
        int busy_cycles;

        // Reset held three cycles, then idle with no start
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle16("rst");
        check("rst_dut1_cnt", cnt1, 0);

        // NUM_PAT=1, bit faults on Y=8'h01: SA0 only at loc0, SA1 at loc1..7, INV everywhere
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k_done = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy1) busy_cycles++;
            if (done1) begin
                k_done = k;
                break;
            end
            @(negedge clk);
        end
        check("p1_busy_cycles", busy_cycles, 72);
        check("p1_done_cycle", k_done, 73);
        check("p1_det_cnt", cnt1, 16);
        check("p1_done_type", type1, 0);
        check("p1_done_ops", {a1, b1, c1}, 20'h00001);
`ifdef CFI_CAMP_MAP_EN
        check("p1_det_map", map1, 24'hDB6DB5);
`endif

        // Transparent datapath: nothing is detectable
        bf16 = 1'b0;
        run16("transp", 0, 1'b0, 5'd0, 24'h000000);

        // Bit faults with repeated start pulses while busy
        bf16 = 1'b1;
        run16("bitf", 0, 1'b1, 5'd24, 24'hFFFFFF);
        repeat (3) @(negedge clk);
        check("done_hold", done16, 1);
        check("done_busy", busy16, 0);
        check("done_type", type16, 0);
        check("done_cnt_hold", cnt16, 24);

        // Restart from DONE clears done/det_cnt and reruns
        run16("rerun", 0, 1'b0, 5'd24, 24'hFFFFFF);

        // Reset mid-campaign, then a fresh start reproduces the operand sequence
        run16("abort", 100, 1'b0, 5'd0, 24'h000000);
        repeat (2) @(negedge clk);
        check("post_abort_done", done16, 0);
        run16("restart", 0, 1'b0, 5'd24, 24'hFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
